plab3_mem_l2_req_arbiter: RTL and testbench
===========================================

PLAB3_MEM_L2_REQ_ARBITER -- requirements
Module: plab3_mem_l2_req_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 The block SHALL have parameter p_opaque_nbits, default 8, the opaque field width (o).
REQ-003 The block SHALL have parameter abw, default 32, the address width.
REQ-004 The block SHALL have parameter clw, default 128, the data/cacheline width.
REQ-005 The block SHALL have port clk, input, 1 bit: the clock.
REQ-006 The block SHALL have port reset, input, 1 bit: asynchronous active-high reset.
REQ-007 The block SHALL have ports reqN_msg (N=0,1), input, VC_MEM_REQ_MSG_NBITS(o,abw,clw) bits: L1 miss request (port 0 = I-side, port 1 = D-side).
REQ-008 The block SHALL have ports reqN_val / reqN_rdy, input / output, 1 bit each: request handshake.
REQ-009 The block SHALL have ports reqN_insecure, input, 1 bit: the request originates from the insecure world; sampled with reqN_msg.
REQ-010 The block SHALL have ports respN_msg, output, VC_MEM_RESP_MSG_NBITS(o,clw) bits: routed response.
REQ-011 The block SHALL have ports respN_val / respN_rdy, output / input, 1 bit each: response handshake.
REQ-012 The block SHALL have ports l2req_msg / l2req_val / l2req_rdy, output / output / input: request to the blocking L2 cache.
REQ-013 The block SHALL have port l2req_insecure, output, 1 bit: drives the L2 insecure input.
REQ-014 The block SHALL have ports l2resp_msg / l2resp_val / l2resp_rdy, input / input / output: response from the L2 cache.

Function
REQ-015 The block SHALL keep at most one transaction outstanding, using FSM states IDLE, SEND, WAIT and RESP.
REQ-016 In IDLE, the winner SHALL be the only valid port if exactly one port is valid; if both ports are valid, the winner SHALL be the port selected by priority pointer ptr.
REQ-017 reqN_rdy SHALL be 1 only in IDLE and only for the winner; the loser's rdy SHALL be 0.
REQ-018 When the winner's val&rdy are both high, the block SHALL register msg, insecure and winner id, set ptr to the other port, and go to SEND.
REQ-019 In SEND, l2req_val SHALL be 1, and l2req_msg and l2req_insecure SHALL come from the registers, unmodified (opaque passes through).
REQ-020 In SEND, l2req_val&l2req_rdy SHALL cause a transition to WAIT; the request SHALL be held stable while rdy is 0.
REQ-021 In WAIT, l2resp_rdy SHALL be 1; l2resp_val SHALL capture l2resp_msg into a register and cause a transition to RESP.
REQ-022 In RESP, respW_val SHALL be 1 only for the registered winner W, and respW_msg SHALL equal the captured response.
REQ-023 In RESP, respW_rdy SHALL cause a transition to IDLE; no request SHALL be accepted in the same cycle (one-cycle bubble).
REQ-024 Minimum latency SHALL be 3 cycles: accept at cycle 0, l2req_val at cycle 1, response captured at cycle 2, respW_val at cycle 3.
REQ-025 In all states other than WAIT, l2resp_rdy SHALL be 0; in all states other than IDLE, both reqN_rdy SHALL be 0.
REQ-026 The non-winner resp port SHALL have val 0 at all times.

Reset
REQ-027 Reset SHALL asynchronously force state to IDLE and ptr to 0, and clear all registers.
REQ-028 While reset is high, all outputs SHALL be 0.
REQ-029 Reset mid-transaction SHALL abandon the transaction; no response SHALL be delivered afterward.

Configuration
REQ-030 When PLAB3_MEM_L2_ARB_GRANT_CNT_EN is defined, the block SHALL add output ports grant_cnt0 and grant_cnt1, 16 bits each.
REQ-031 Each grant_cntN SHALL increment on every accepted request from port N, saturate at 16'hFFFF, and reset to 0.
REQ-032 When PLAB3_MEM_L2_ARB_GRANT_CNT_EN is undefined, the ports and counters SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-033 Scenario (single port): req0 only, addr 0x1000, l2req_rdy=1, L2 responds next cycle -> l2req_val at cycle 1, resp0_val at cycle 3 with the L2 data; resp1_val stays 0.
REQ-034 Scenario (round-robin): both ports valid continuously for 4 transactions after reset -> grant order is 0,1,0,1.
REQ-035 Scenario (backpressure): l2req_rdy=0 for 5 cycles, then resp0_rdy=0 for 3 cycles -> l2req_msg and resp0_msg are held stable, with no new grant during either stall.
REQ-036 Scenario (security forwarding): req1_insecure=1, req0_insecure=0, alternating grants -> l2req_insecure equals 1 exactly during port-1 SEND cycles.
REQ-037 Scenario (reset mid-transaction): reset pulsed in WAIT, then a stale l2resp_val arrives -> no respN_val is asserted, and the next grant goes to port 0.
REQ-038 Scenario (counter): with PLAB3_MEM_L2_ARB_GRANT_CNT_EN defined, 3 grants on port 0 and 2 grants on port 1 -> grant_cnt0=3 and grant_cnt1=2.

Source files
------------

// File: rtl/plab3_mem_l2_req_arbiter_if.sv
// Handshake bundle between the two L1 miss ports, the arbiter and the blocking L2 cache.
// The slave modport is the arbiter's view and the master modport is the environment's view.
interface plab3_mem_l2_req_arbiter_if #(
  parameter int p_opaque_nbits = 8,
  parameter int abw            = 32,
  parameter int clw            = 128
);
  // Request layout: type(3) | opaque | addr | len | data.
  // Response layout: type(3) | opaque | test(2) | len | data.
  localparam int len_nbits  = $clog2(clw / 8);
  localparam int req_nbits  = 3 + p_opaque_nbits + abw + len_nbits + clw;
  localparam int resp_nbits = 3 + p_opaque_nbits + 2 + len_nbits + clw;

  logic [req_nbits-1:0]  req0_msg;
  logic                  req0_val;
  logic                  req0_rdy;
  logic                  req0_insecure;
  logic [req_nbits-1:0]  req1_msg;
  logic                  req1_val;
  logic                  req1_rdy;
  logic                  req1_insecure;

  logic [resp_nbits-1:0] resp0_msg;
  logic                  resp0_val;
  logic                  resp0_rdy;
  logic [resp_nbits-1:0] resp1_msg;
  logic                  resp1_val;
  logic                  resp1_rdy;

  logic [req_nbits-1:0]  l2req_msg;
  logic                  l2req_val;
  logic                  l2req_rdy;
  logic                  l2req_insecure;
  logic [resp_nbits-1:0] l2resp_msg;
  logic                  l2resp_val;
  logic                  l2resp_rdy;

  modport slave (
    input  req0_msg, req0_val, req0_insecure, req1_msg, req1_val, req1_insecure,
    output req0_rdy, req1_rdy,
    output resp0_msg, resp0_val, resp1_msg, resp1_val,
    input  resp0_rdy, resp1_rdy,
    output l2req_msg, l2req_val, l2req_insecure,
    input  l2req_rdy,
    input  l2resp_msg, l2resp_val,
    output l2resp_rdy
  );

  modport master (
    output req0_msg, req0_val, req0_insecure, req1_msg, req1_val, req1_insecure,
    input  req0_rdy, req1_rdy,
    input  resp0_msg, resp0_val, resp1_msg, resp1_val,
    output resp0_rdy, resp1_rdy,
    input  l2req_msg, l2req_val, l2req_insecure,
    output l2req_rdy,
    output l2resp_msg, l2resp_val,
    input  l2resp_rdy
  );
endinterface

// File: rtl/plab3_mem_l2_req_arbiter.sv
// Two-port round-robin arbiter in front of a blocking L2: one transaction in flight (IDLE/SEND/WAIT/RESP).
// Optional per-port saturating grant counters when PLAB3_MEM_L2_ARB_GRANT_CNT_EN is defined.
module plab3_mem_l2_req_arbiter #(
  parameter int p_opaque_nbits = 8,
  parameter int abw            = 32,
  parameter int clw            = 128
) (
  input  logic clk,
  input  logic reset,
  plab3_mem_l2_req_arbiter_if.slave bus
`ifdef PLAB3_MEM_L2_ARB_GRANT_CNT_EN
  ,
  output logic [15:0] grant_cnt0,
  output logic [15:0] grant_cnt1
`endif
);

  localparam int c_len_nbits  = $clog2(clw / 8);
  localparam int c_req_nbits  = 3 + p_opaque_nbits + abw + c_len_nbits + clw;
  localparam int c_resp_nbits = 3 + p_opaque_nbits + 2 + c_len_nbits + clw;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  logic [1:0]              r_state;
  logic                    r_ptr;
  logic                    r_owner;
  logic                    r_insecure;
  logic [c_req_nbits-1:0]  r_req_msg;
  logic [c_resp_nbits-1:0] r_resp_msg;

  logic [1:0] w_state_nxt;
  logic       w_idle;
  logic       w_send;
  logic       w_wait;
  logic       w_resp;
  logic       w_winner;
  logic       w_win_val;
  logic       w_accept;
  logic       w_resp_rdy;

  // Reset is folded into the IDLE decode so no grant is offered while reset is held.
  assign w_idle = (r_state == IDLE) & ~reset;
  assign w_send = (r_state == SEND);
  assign w_wait = (r_state == WAIT);
  assign w_resp = (r_state == RESP);

  assign w_winner  = (bus.req0_val & bus.req1_val) ? r_ptr : bus.req1_val;
  assign w_win_val = w_winner ? bus.req1_val : bus.req0_val;
  assign w_accept  = w_idle & w_win_val;

  assign bus.req0_rdy = w_idle & ~w_winner;
  assign bus.req1_rdy = w_idle &  w_winner;

  assign bus.l2req_val      = w_send;
  assign bus.l2req_msg      = r_req_msg;
  assign bus.l2req_insecure = w_send & r_insecure;

  assign bus.l2resp_rdy = w_wait;

  assign w_resp_rdy    = r_owner ? bus.resp1_rdy : bus.resp0_rdy;
  assign bus.resp0_val = w_resp & ~r_owner;
  assign bus.resp1_val = w_resp &  r_owner;
  assign bus.resp0_msg = r_resp_msg;
  assign bus.resp1_msg = r_resp_msg;

  // NOTE: default assignment first keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)       w_state_nxt = SEND;
      SEND:    if (bus.l2req_rdy)  w_state_nxt = WAIT;
      WAIT:    if (bus.l2resp_val) w_state_nxt = RESP;
      RESP:    if (w_resp_rdy)     w_state_nxt = IDLE;
      default:                     w_state_nxt = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= 1'b0;
      r_owner    <= 1'b0;
      r_insecure <= 1'b0;
      // NOTE: payload registers are cleared too, so message outputs read 0 during reset.
      r_req_msg  <= '0;
      r_resp_msg <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_req_msg  <= w_winner ? bus.req1_msg : bus.req0_msg;
        r_insecure <= w_winner ? bus.req1_insecure : bus.req0_insecure;
        r_owner    <= w_winner;
        r_ptr      <= ~w_winner;
      end
      if (w_wait & bus.l2resp_val) begin
        r_resp_msg <= bus.l2resp_msg;
      end
    end
  end

`ifdef PLAB3_MEM_L2_ARB_GRANT_CNT_EN
  logic [15:0] r_grant_cnt0;
  logic [15:0] r_grant_cnt1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_grant_cnt0 <= 16'd0;
      r_grant_cnt1 <= 16'd0;
    end else begin
      if (w_accept & ~w_winner & (r_grant_cnt0 != 16'hFFFF)) r_grant_cnt0 <= r_grant_cnt0 + 16'd1;
      if (w_accept &  w_winner & (r_grant_cnt1 != 16'hFFFF)) r_grant_cnt1 <= r_grant_cnt1 + 16'd1;
    end
  end

  assign grant_cnt0 = r_grant_cnt0;
  assign grant_cnt1 = r_grant_cnt1;
`endif

endmodule

// File: tb/tb_plab3_mem_l2_req_arbiter.sv
// Scenario bench for the L2 request arbiter: transaction-level reference model (grant pointer,
// expected winner, payloads) checked cycle by cycle through each handshake phase.
module tb_plab3_mem_l2_req_arbiter;

  localparam int LENW  = $clog2(128 / 8);
  localparam int REQW  = 3 + 8 + 32 + LENW + 128;
  localparam int RESPW = 3 + 8 + 2 + LENW + 128;

  typedef logic [REQW-1:0]  req_t;
  typedef logic [RESPW-1:0] resp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference model: next-preferred port and grants per port since the last reset.
  int m_ptr = 0;
  int m_grants[2] = '{0, 0};

  always #5 clk = ~clk;

  plab3_mem_l2_req_arbiter_if bus ();

`ifdef PLAB3_MEM_L2_ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
  plab3_mem_l2_req_arbiter dut (
    .clk(clk), .reset(reset), .bus(bus), .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
  );
`else
  plab3_mem_l2_req_arbiter dut (.clk(clk), .reset(reset), .bus(bus));
`endif

  function automatic req_t rand_req();
    req_t r;
    for (int i = 0; i < REQW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  function automatic resp_t rand_resp();
    resp_t r;
    for (int i = 0; i < RESPW; i++) r[i] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic clear_inputs();
    bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    bus.req0_msg = '0;   bus.req1_msg = '0;
    bus.req0_insecure = 1'b0; bus.req1_insecure = 1'b0;
    bus.resp0_rdy = 1'b0; bus.resp1_rdy = 1'b0;
    bus.l2req_rdy = 1'b0;
    bus.l2resp_val = 1'b0; bus.l2resp_msg = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0;
    m_grants = '{0, 0};
  endtask

  // One complete transaction: grant, SEND (with l2req stalls), WAIT (with L2 delay), RESP (with stalls).
  task automatic drive_txn(input string tag, input bit v0, input bit v1, input req_t m0, input req_t m1,
                           input bit ins0, input bit ins1, input int s_stall, input int w_dly,
                           input int r_stall, input resp_t rdata);
    int   w;
    req_t em;
    bit   ei;
    w  = (v0 && v1) ? m_ptr : (v1 ? 1 : 0);
    em = (w == 1) ? m1 : m0;
    ei = (w == 1) ? ins1 : ins0;

    bus.req0_val = v0; bus.req1_val = v1;
    bus.req0_msg = m0; bus.req1_msg = m1;
    bus.req0_insecure = ins0; bus.req1_insecure = ins1;
    @(negedge clk);
    n_total++;
    if (bus.req0_rdy !== (w == 0) || bus.req1_rdy !== (w == 1))
      $display("FAIL %s grant: rdy0=%0b rdy1=%0b, want winner %0d", tag, bus.req0_rdy, bus.req1_rdy, w);
    else n_pass++;
    n_total++;
    if (bus.l2req_val !== 1'b0 || bus.l2req_insecure !== 1'b0 || bus.resp0_val !== 1'b0 || bus.resp1_val !== 1'b0)
      $display("FAIL %s idle_quiet: l2req_val=%0b ins=%0b resp_val=%0b%0b, want 0", tag,
               bus.l2req_val, bus.l2req_insecure, bus.resp1_val, bus.resp0_val);
    else n_pass++;
    @(posedge clk); #1;
    m_ptr = 1 - w;
    m_grants[w]++;

    for (int i = 0; i <= s_stall; i++) begin
      bus.l2req_rdy = (i == s_stall);
      @(negedge clk);
      n_total++;
      if (bus.l2req_val !== 1'b1 || bus.l2req_msg !== em || bus.l2req_insecure !== ei)
        $display("FAIL %s send[%0d]: val=%0b ins=%0b msg=%h, want 1 %0b %h", tag, i,
                 bus.l2req_val, bus.l2req_insecure, bus.l2req_msg, ei, em);
      else n_pass++;
      n_total++;
      if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0 || bus.l2resp_rdy !== 1'b0 ||
          bus.resp0_val !== 1'b0 || bus.resp1_val !== 1'b0)
        $display("FAIL %s send_quiet[%0d]: rdy=%0b%0b l2resp_rdy=%0b resp_val=%0b%0b, want 0", tag, i,
                 bus.req1_rdy, bus.req0_rdy, bus.l2resp_rdy, bus.resp1_val, bus.resp0_val);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.l2req_rdy = 1'b0;

    for (int i = 0; i <= w_dly; i++) begin
      bus.l2resp_val = (i == w_dly);
      bus.l2resp_msg = (i == w_dly) ? rdata : rand_resp();
      @(negedge clk);
      n_total++;
      if (bus.l2resp_rdy !== 1'b1 || bus.l2req_val !== 1'b0 || bus.l2req_insecure !== 1'b0 ||
          bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0 || bus.resp0_val !== 1'b0 || bus.resp1_val !== 1'b0)
        $display("FAIL %s wait[%0d]: l2resp_rdy=%0b l2req_val=%0b ins=%0b rdy=%0b%0b resp_val=%0b%0b, want 1 0 0 00 00",
                 tag, i, bus.l2resp_rdy, bus.l2req_val, bus.l2req_insecure, bus.req1_rdy, bus.req0_rdy,
                 bus.resp1_val, bus.resp0_val);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.l2resp_val = 1'b0;
    bus.l2resp_msg = rand_resp();

    for (int i = 0; i <= r_stall; i++) begin
      if (w == 0) begin bus.resp0_rdy = (i == r_stall); bus.resp1_rdy = 1'($urandom_range(0, 1)); end
      else        begin bus.resp1_rdy = (i == r_stall); bus.resp0_rdy = 1'($urandom_range(0, 1)); end
      @(negedge clk);
      n_total++;
      if (bus.resp0_val !== (w == 0) || bus.resp1_val !== (w == 1) ||
          ((w == 0) ? bus.resp0_msg : bus.resp1_msg) !== rdata)
        $display("FAIL %s resp[%0d]: val=%0b%0b msg=%h, want port %0d msg %h", tag, i,
                 bus.resp1_val, bus.resp0_val, (w == 0) ? bus.resp0_msg : bus.resp1_msg, w, rdata);
      else n_pass++;
      n_total++;
      if (bus.req0_rdy !== 1'b0 || bus.req1_rdy !== 1'b0 || bus.l2req_val !== 1'b0 ||
          bus.l2resp_rdy !== 1'b0 || bus.l2req_insecure !== 1'b0)
        $display("FAIL %s resp_quiet[%0d]: rdy=%0b%0b l2req_val=%0b l2resp_rdy=%0b ins=%0b, want 0", tag, i,
                 bus.req1_rdy, bus.req0_rdy, bus.l2req_val, bus.l2resp_rdy, bus.l2req_insecure);
      else n_pass++;
      @(posedge clk); #1;
    end
    bus.resp0_rdy = 1'b0; bus.resp1_rdy = 1'b0;
    bus.req0_val = 1'b0;  bus.req1_val = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    bus.req0_val = 1'b1; bus.req1_val = 1'b1;
    bus.l2req_rdy = 1'b1; bus.l2resp_val = 1'b1; bus.l2resp_msg = rand_resp();
    bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_total++;
    if ({bus.req0_rdy, bus.req1_rdy, bus.l2req_val, bus.l2req_insecure, bus.l2resp_rdy,
         bus.resp0_val, bus.resp1_val} !== 7'b0)
      $display("FAIL reset_ctrl: rdy=%0b%0b l2req_val=%0b ins=%0b l2resp_rdy=%0b resp_val=%0b%0b, want 0",
               bus.req1_rdy, bus.req0_rdy, bus.l2req_val, bus.l2req_insecure, bus.l2resp_rdy,
               bus.resp1_val, bus.resp0_val);
    else n_pass++;
    n_total++;
    if (bus.l2req_msg !== '0 || bus.resp0_msg !== '0 || bus.resp1_msg !== '0)
      $display("FAIL reset_msgs: l2req=%h resp0=%h resp1=%h, want 0", bus.l2req_msg, bus.resp0_msg, bus.resp1_msg);
    else n_pass++;
    @(posedge clk); #1;
    clear_inputs();
    bus.req0_val = 1'b1; bus.req1_val = 1'b1;
    reset = 1'b0;
    m_ptr = 0;
    m_grants = '{0, 0};
    @(negedge clk);
    n_total++;
    if (bus.req0_rdy !== 1'b1 || bus.req1_rdy !== 1'b0)
      $display("FAIL reset_ptr: rdy0=%0b rdy1=%0b, want 1 0", bus.req0_rdy, bus.req1_rdy);
    else n_pass++;
    bus.req0_val = 1'b0; bus.req1_val = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_port();
    req_t m0;
    m0 = {3'd0, 8'h5A, 32'h0000_1000, {LENW{1'b0}}, 128'h0};
    drive_txn("single_port", 1'b1, 1'b0, m0, rand_req(), 1'b0, 1'b0, 0, 0, 0, rand_resp());
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 4; i++)
      drive_txn($sformatf("round_robin%0d", i), 1'b1, 1'b1, rand_req(), rand_req(), 1'b0, 1'b0, 0, 0, 0,
                rand_resp());
  endtask

  task automatic test_backpressure();
    drive_txn("backpressure", 1'b1, 1'b1, rand_req(), rand_req(), 1'b0, 1'b1, 5, 0, 3, rand_resp());
  endtask

  task automatic test_security();
    for (int i = 0; i < 4; i++)
      drive_txn($sformatf("security%0d", i), 1'b1, 1'b1, rand_req(), rand_req(), 1'b0, 1'b1,
                i % 2, 1, 0, rand_resp());
  endtask

  task automatic test_reset_mid();
    apply_reset();
    bus.req1_val = 1'b1; bus.req1_msg = rand_req();
    @(posedge clk); #1;
    bus.req1_val = 1'b0;
    bus.l2req_rdy = 1'b1;
    @(posedge clk); #1;
    bus.l2req_rdy = 1'b0;
    @(negedge clk);
    n_total++;
    if (bus.l2resp_rdy !== 1'b1)
      $display("FAIL reset_mid_wait: l2resp_rdy=%0b, want 1", bus.l2resp_rdy);
    else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++;
    if ({bus.req0_rdy, bus.req1_rdy, bus.l2req_val, bus.l2resp_rdy, bus.resp0_val, bus.resp1_val} !== 6'b0)
      $display("FAIL reset_mid_async: rdy=%0b%0b l2req_val=%0b l2resp_rdy=%0b resp_val=%0b%0b, want 0",
               bus.req1_rdy, bus.req0_rdy, bus.l2req_val, bus.l2resp_rdy, bus.resp1_val, bus.resp0_val);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ptr = 0;
    m_grants = '{0, 0};
    bus.l2resp_val = 1'b1; bus.l2resp_msg = rand_resp();
    bus.resp0_rdy = 1'b1; bus.resp1_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (bus.resp0_val !== 1'b0 || bus.resp1_val !== 1'b0 || bus.l2resp_rdy !== 1'b0)
        $display("FAIL reset_mid_stale[%0d]: resp_val=%0b%0b l2resp_rdy=%0b, want 0", i,
                 bus.resp1_val, bus.resp0_val, bus.l2resp_rdy);
      else n_pass++;
      @(posedge clk); #1;
    end
    clear_inputs();
    drive_txn("reset_mid_next", 1'b1, 1'b1, rand_req(), rand_req(), 1'b0, 1'b1, 0, 0, 0, rand_resp());
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int v;
      v = $urandom_range(1, 3);
      drive_txn($sformatf("random%0d", i), v[0], v[1], rand_req(), rand_req(),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), rand_resp());
    end
`ifdef PLAB3_MEM_L2_ARB_GRANT_CNT_EN
    n_total++;
    if (grant_cnt0 !== 16'(m_grants[0]) || grant_cnt1 !== 16'(m_grants[1]))
      $display("FAIL random_cnt: cnt0=%0d cnt1=%0d, want %0d %0d", grant_cnt0, grant_cnt1, m_grants[0], m_grants[1]);
    else n_pass++;
`endif
  endtask

`ifdef PLAB3_MEM_L2_ARB_GRANT_CNT_EN
  task automatic test_counter();
    apply_reset();
    n_total++;
    if (grant_cnt0 !== 16'd0 || grant_cnt1 !== 16'd0)
      $display("FAIL counter_reset: cnt0=%0d cnt1=%0d, want 0 0", grant_cnt0, grant_cnt1);
    else n_pass++;
    for (int i = 0; i < 3; i++)
      drive_txn("counter_p0", 1'b1, 1'b0, rand_req(), rand_req(), 1'b0, 1'b0, 0, 0, 0, rand_resp());
    for (int i = 0; i < 2; i++)
      drive_txn("counter_p1", 1'b0, 1'b1, rand_req(), rand_req(), 1'b0, 1'b0, 0, 0, 0, rand_resp());
    n_total++;
    if (grant_cnt0 !== 16'd3 || grant_cnt1 !== 16'd2)
      $display("FAIL counter: cnt0=%0d cnt1=%0d, want 3 2", grant_cnt0, grant_cnt1);
    else n_pass++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_port();
    test_round_robin();
    test_backpressure();
    test_security();
    test_reset_mid();
    test_random();
`ifdef PLAB3_MEM_L2_ARB_GRANT_CNT_EN
    test_counter();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
